multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I core; time-shares one ALU across fetch, decode, execute, memory and writeback.
- Drives operand-select codes ASel/BSel (00 = zero, 01 = pc/imm, 10 = register data) into the ALU operand mux.
- Drives datapath write strobes and a handshake to the unified instruction/data memory.
- Reads the opcode from the datapath instruction register, which is stable from the cycle after an IR write.

---
 rtl/multicycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: one shared ALU stepped through fetch, decode,
// execute, memory and writeback, with a sticky trap on illegal opcodes and memory timeouts.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic [1:0] ASel,
  output logic [1:0] BSel,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       aluout_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       trap_q, trap_d;
  logic [1:0] cause_q, cause_d;

  logic is_r, is_ialu, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic is_legal, limit_hit;

  assign is_r      = (opcode == OP_R);
  assign is_ialu   = (opcode == OP_IALU);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_legal  = is_r | is_ialu | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;
  assign limit_hit = (cnt_q == LIMIT);

  // The wait counter only survives a cycle spent stalled in FETCH/MEM; any other
  // path (state change or mem_ready) returns it to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    trap_d  = trap_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH, S_MEM: begin
        if (mem_ready) begin
          if (state_q == S_FETCH) state_d = S_DECODE;
          else                    state_d = is_load ? S_WB : S_FETCH;
        end else if (limit_hit) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        if (is_branch)               state_d = S_FETCH;
        else if (is_load | is_store) state_d = S_MEM;
        else                         state_d = S_WB;
      end
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    ASel      = 2'b00;
    BSel      = 2'b00;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    aluout_we = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_DECODE: begin
        ASel      = 2'b01;
        BSel      = 2'b01;
        aluout_we = 1'b1;
      end
      S_EXEC: begin
        if (is_r | is_branch) begin
          ASel = 2'b10;
          BSel = 2'b10;
        end else if (is_ialu | is_load | is_store | is_jalr) begin
          ASel = 2'b10;
          BSel = 2'b01;
        end else if (is_lui) begin
          ASel = 2'b00;
          BSel = 2'b01;
        end else if (is_auipc | is_jal) begin
          ASel = 2'b01;
          BSel = 2'b01;
        end
        // A branch leaves ALUOut holding the target computed in DECODE.
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_src = br_taken;
        end else begin
          aluout_we = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        pc_we   = is_store & mem_ready;
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        pc_src = is_jal | is_jalr;
        if (is_load)              wb_sel = 2'b01;
        else if (is_jal | is_jalr) wb_sel = 2'b10;
      end
      default: ;
    endcase
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into the per-cycle
// trace the sequencer must produce, then replayed against the DUT cycle by cycle.
module tb_multicycle_ctrl;

  localparam int TMO = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

  localparam logic [6:0] OP_R = 7'b0110011, OP_IALU = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [6:0] op;
    logic       rdy;
    logic       tk;
    logic [2:0] st;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic       mreq;
    logic       mwe;
    logic       irwe;
    logic       aluwe;
    logic       pcwe;
    logic       pcsrc;
    logic       regwe;
    logic [1:0] wbsel;
    logic       trp;
    logic [1:0] cause;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic [1:0] ASel, BSel, wb_sel, trap_cause;
  logic       mem_req, mem_we, ir_we, aluout_we, pc_we, pc_src, reg_we, trap;
  logic [2:0] state_o;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
    .ASel(ASel), .BSel(BSel), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .aluout_we(aluout_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    pc_pulses = 0;
  int    exp_retired = 0;
  int    memreq_cycles = 0;
  string cur_test = "";
  cyc_t  exp_q[$];

  // ---------------- reference model ----------------
  function automatic bit is_legal(logic [6:0] op);
    return op inside {OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
                      OP_LUI, OP_AUIPC};
  endfunction

  function automatic logic [6:0] legal_op(int idx);
    case (idx)
      0: return OP_R;      1: return OP_IALU;   2: return OP_LOAD;
      3: return OP_STORE;  4: return OP_BRANCH; 5: return OP_JAL;
      6: return OP_JALR;   7: return OP_LUI;    default: return OP_AUIPC;
    endcase
  endfunction

  // Operand-select pair {ASel, BSel} the ALU needs in EXEC for each instruction kind.
  function automatic logic [3:0] exec_sel(logic [6:0] op);
    case (op)
      OP_R, OP_BRANCH:                     return 4'b10_10;
      OP_IALU, OP_LOAD, OP_STORE, OP_JALR: return 4'b10_01;
      OP_LUI:                              return 4'b00_01;
      default:                             return 4'b01_01;
    endcase
  endfunction

  function automatic cyc_t blank(logic [2:0] st);
    cyc_t c;
    c     = '0;
    c.st  = st;
    c.op  = 7'($urandom);
    c.rdy = 1'($urandom);
    c.tk  = 1'($urandom);
    return c;
  endfunction

  task automatic push_trap(input logic [1:0] cause, input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c       = blank(S_TRAP);
      c.trp   = 1'b1;
      c.cause = cause;
      exp_q.push_back(c);
    end
  endtask

  // fw/mw: number of cycles mem_ready stays low in FETCH/MEM before it answers.
  task automatic add_instr(input logic [6:0] op, input logic tk, input int fw, input int mw);
    cyc_t c;
    bit   ls;
    ls = (op == OP_LOAD) || (op == OP_STORE);
    for (int i = 0; i < fw && i <= TMO; i++) begin
      c = blank(S_FETCH); c.rdy = 1'b0; c.mreq = 1'b1;
      exp_q.push_back(c);
    end
    if (fw > TMO) begin push_trap(2'b10, 4); return; end
    c = blank(S_FETCH); c.rdy = 1'b1; c.mreq = 1'b1; c.irwe = 1'b1;
    exp_q.push_back(c);
    c = blank(S_DECODE); c.op = op; c.asel = 2'b01; c.bsel = 2'b01; c.aluwe = 1'b1;
    exp_q.push_back(c);
    if (!is_legal(op)) begin push_trap(2'b01, 20); return; end
    c = blank(S_EXEC); c.op = op;
    {c.asel, c.bsel} = exec_sel(op);
    if (op == OP_BRANCH) begin
      c.tk = tk; c.pcwe = 1'b1; c.pcsrc = tk;
      exp_q.push_back(c);
      exp_retired++;
      return;
    end
    c.aluwe = 1'b1;
    exp_q.push_back(c);
    if (ls) begin
      for (int i = 0; i < mw && i <= TMO; i++) begin
        c = blank(S_MEM); c.op = op; c.rdy = 1'b0; c.mreq = 1'b1; c.mwe = (op == OP_STORE);
        exp_q.push_back(c);
      end
      if (mw > TMO) begin push_trap(2'b10, 4); return; end
      c = blank(S_MEM); c.op = op; c.rdy = 1'b1; c.mreq = 1'b1; c.mwe = (op == OP_STORE);
      c.pcwe = (op == OP_STORE);
      exp_q.push_back(c);
      if (op == OP_STORE) begin exp_retired++; return; end
    end
    c = blank(S_WB); c.op = op; c.regwe = 1'b1; c.pcwe = 1'b1;
    c.pcsrc = (op == OP_JAL) || (op == OP_JALR);
    c.wbsel = (op == OP_LOAD) ? 2'b01 : c.pcsrc ? 2'b10 : 2'b00;
    exp_q.push_back(c);
    exp_retired++;
  endtask

  // ---------------- driver / scoreboard ----------------
  function automatic logic [18:0] pack_exp(cyc_t c);
    return {c.st, c.asel, c.bsel, c.mreq, c.mwe, c.irwe, c.aluwe, c.pcwe, c.pcsrc,
            c.regwe, c.wbsel, c.trp, c.cause};
  endfunction

  function automatic logic [18:0] pack_obs();
    return {state_o, ASel, BSel, mem_req, mem_we, ir_we, aluout_we, pc_we, pc_src,
            reg_we, wb_sel, trap, trap_cause};
  endfunction

  task automatic run_one();
    cyc_t        c;
    logic [18:0] e, o;
    c = exp_q.pop_front();
    @(negedge clk);
    opcode    = c.op;
    mem_ready = c.rdy;
    br_taken  = c.tk;
    #1;
    e = pack_exp(c);
    o = pack_obs();
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL %s: state=%0d outs=%b, expected state=%0d outs=%b",
               cur_test, o[18:16], o, e[18:16], e);
    end
    if (pc_we === 1'b1) pc_pulses++;
    if (mem_req === 1'b1) memreq_cycles++;
  endtask

  task automatic run_queue();
    while (exp_q.size() > 0) run_one();
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    exp_q.push_back(blank(S_IDLE));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cur_test = "reset";
    #3;
    checks++;
    if (pack_obs() !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs: outs=%b, expected all zero", pack_obs());
    end
    do_reset();
    run_queue();
  endtask

  task automatic test_alu();
    cur_test = "alu_rtype";
    do_reset();
    add_instr(OP_R, 1'b0, 0, 0);
    add_instr(OP_R, 1'b0, 0, 0);
    run_queue();
  endtask

  task automatic test_load_wait();
    cur_test = "load_wait";
    do_reset();
    add_instr(OP_LOAD, 1'b0, 0, 3);
    run_queue();
    checks++;
    if (memreq_cycles != 5) begin
      failures++;
      $display("FAIL load_memreq_cycles: got %0d, expected 5 (1 fetch + 4 mem)", memreq_cycles);
    end
  endtask

  task automatic test_branch();
    cur_test = "branch";
    do_reset();
    add_instr(OP_BRANCH, 1'b1, 0, 0);
    add_instr(OP_BRANCH, 1'b0, 0, 0);
    add_instr(OP_R, 1'b0, 0, 0);
    run_queue();
  endtask

  task automatic test_jal_lui();
    cur_test = "jal_lui_mix";
    do_reset();
    add_instr(OP_JAL, 1'b0, 0, 0);
    add_instr(OP_LUI, 1'b0, 0, 0);
    add_instr(OP_JALR, 1'b0, 1, 0);
    add_instr(OP_AUIPC, 1'b0, 0, 0);
    add_instr(OP_STORE, 1'b0, 0, 2);
    add_instr(OP_IALU, 1'b0, 2, 0);
    run_queue();
  endtask

  task automatic test_illegal();
    logic [6:0] op;
    cur_test = "illegal_zero";
    do_reset();
    add_instr(7'b0000000, 1'b0, 0, 0);
    run_queue();
    cur_test = "illegal_recover";
    do_reset();
    add_instr(OP_R, 1'b0, 0, 0);
    run_queue();
    cur_test = "illegal_random";
    op = 7'($urandom);
    if (is_legal(op)) op = 7'b1111111;
    do_reset();
    add_instr(op, 1'b0, 0, 0);
    run_queue();
  endtask

  task automatic test_timeout();
    cur_test = "fetch_timeout";
    do_reset();
    add_instr(OP_R, 1'b0, TMO + 1, 0);
    run_queue();
    cur_test = "fetch_ready_at_limit";
    do_reset();
    add_instr(OP_R, 1'b0, TMO, 0);
    run_queue();
    cur_test = "mem_timeout";
    do_reset();
    add_instr(OP_STORE, 1'b0, 0, TMO + 1);
    run_queue();
    cur_test = "mem_ready_at_limit";
    do_reset();
    add_instr(OP_LOAD, 1'b0, 0, TMO);
    run_queue();
  endtask

  task automatic test_reset_mid_mem();
    cur_test = "reset_mid_mem";
    do_reset();
    add_instr(OP_LOAD, 1'b0, 0, 3);
    for (int i = 0; i < 5; i++) run_one();
    exp_q.delete();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || state_o !== S_IDLE) begin
      failures++;
      $display("FAIL reset_mid_mem: mem_req=%b state=%0d, expected mem_req=0 state=0",
               mem_req, state_o);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    cur_test = "random_stream";
    do_reset();
    run_queue();
    pc_pulses   = 0;
    exp_retired = 0;
    n = 40;
    for (int i = 0; i < n; i++) begin
      add_instr(legal_op($urandom_range(0, 8)), 1'($urandom), $urandom_range(0, TMO),
                $urandom_range(0, TMO));
    end
    run_queue();
    checks++;
    if (pc_pulses != exp_retired) begin
      failures++;
      $display("FAIL pc_we_per_retire: pulses=%0d, expected %0d", pc_pulses, exp_retired);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    memreq_cycles = 0;
    test_load_wait();
    test_branch();
    test_jal_lui();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
